tx_iq_unpack: RTL and testbench

TX_IQ_UNPACK -- requirements
Module: tx_iq_unpack

---
 rtl/tx_iq_unpack_if.sv | 43 ++++
 rtl/tx_iq_unpack.sv | 134 +++++++++++++
 tb/tb_tx_iq_unpack.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_iq_unpack_if.sv
// ---------------------------------------------------------------------------
// tx_iq_unpack_if
// Bus bundle between the Tx byte FIFO / DUC side and the I/Q unpacker.
//   master : the FIFO + DUC environment (drives run, fifo_data, fifo_empty,
//            sample_req; observes the unpacker outputs)
//   slave  : the unpacker itself
// Signals:
//   run             PC run enable, 0 = idle and flush
//   fifo_data       Tx byte, valid one cycle after fifo_rdreq
//   fifo_empty      FIFO holds no bytes
//   fifo_rdreq      one-cycle read strobe to the FIFO
//   fifo_clear      synchronous FIFO flush request
//   sample_req      one-cycle strobe from the DUC for the next sample
//   I_out / Q_out   transmit sample, two's complement
//   iq_valid        one-cycle pulse, I_out/Q_out updated in the same cycle
//   underflow       one-cycle pulse on an iq_valid without a fresh sample
//   underflow_count saturating underflow event count
// ---------------------------------------------------------------------------
interface tx_iq_unpack_if;
    logic               run;
    logic        [7:0]  fifo_data;
    logic               fifo_empty;
    logic               fifo_rdreq;
    logic               fifo_clear;
    logic               sample_req;
    logic signed [23:0] I_out;
    logic signed [23:0] Q_out;
    logic               iq_valid;
    logic               underflow;
    logic        [15:0] underflow_count;

    modport master (
        output run, fifo_data, fifo_empty, sample_req,
        input  fifo_rdreq, fifo_clear, I_out, Q_out, iq_valid, underflow,
               underflow_count
    );

    modport slave (
        input  run, fifo_data, fifo_empty, sample_req,
        output fifo_rdreq, fifo_clear, I_out, Q_out, iq_valid, underflow,
               underflow_count
    );
endinterface

// File: rtl/tx_iq_unpack.sv
// ---------------------------------------------------------------------------
// tx_iq_unpack
// Pulls six bytes per sample from a non-show-ahead Tx FIFO and assembles
// them into a 24-bit I / 24-bit Q pair (byte order I hi..lo, Q hi..lo).
// A completed sample waits in a holding register until the DUC strobes
// sample_req; a request that finds no completed sample is an underflow.
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   synchronous active-high reset
//   bus       tx_iq_unpack_if.slave (FIFO side, DUC side, status)
// Parameter:
//   UNDERFLOW_ZERO  1 = output zero on underflow, 0 = repeat last sample
// ---------------------------------------------------------------------------
module tx_iq_unpack #(
    parameter bit UNDERFLOW_ZERO = 1'b1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    tx_iq_unpack_if.slave  bus
);

    typedef enum logic [1:0] {CLEAR, FETCH, CAPTURE, HOLD} state_t;

    state_t             r_state;
    logic               r_fifo_clear;
    logic        [2:0]  r_idx;
    logic               r_hold_vld;
    logic        [47:0] r_hold;
    logic signed [23:0] r_i_out;
    logic signed [23:0] r_q_out;
    logic               r_iq_valid;
    logic               r_underflow;
    logic        [15:0] r_ucount;

    logic        [2:0]  w_slot;
    logic               w_svc;

    // Byte 0 lands in the top of the 48-bit holding word.
    assign w_slot = 3'd5 - r_idx;
    assign w_svc  = bus.run & bus.sample_req;

    // The read strobe has to follow fifo_empty in the same cycle, otherwise a
    // read could be issued against a FIFO that just went empty; it is decoded
    // from the state register rather than registered.
    assign bus.fifo_rdreq = (r_state == FETCH) & bus.run & ~bus.fifo_empty & ~i_reset;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= CLEAR;
            r_fifo_clear <= 1'b1;
            r_idx        <= 3'd0;
            r_hold_vld   <= 1'b0;
            r_i_out      <= '0;
            r_q_out      <= '0;
            r_iq_valid   <= 1'b0;
            r_underflow  <= 1'b0;
            r_ucount     <= 16'd0;
        end else begin
            r_iq_valid  <= 1'b0;
            r_underflow <= 1'b0;

            // Sample service uses the holding-valid flag as registered at the
            // start of the cycle, so a request landing on the completing
            // CAPTURE counts as an underflow and the sample stays held.
            if (w_svc) begin
                r_iq_valid <= 1'b1;
                if (r_hold_vld) begin
                    r_i_out <= r_hold[47:24];
                    r_q_out <= r_hold[23:0];
                end else begin
                    r_underflow <= 1'b1;
                    if (r_ucount != 16'hFFFF)
                        r_ucount <= r_ucount + 16'd1;
                    if (UNDERFLOW_ZERO) begin
                        r_i_out <= '0;
                        r_q_out <= '0;
                    end
                end
            end

            // Dropping run flushes everything, including a read in flight.
            if (!bus.run) begin
                r_state      <= CLEAR;
                r_fifo_clear <= 1'b1;
                r_idx        <= 3'd0;
                r_hold_vld   <= 1'b0;
            end else begin
                case (r_state)
                    CLEAR: begin
                        r_state      <= FETCH;
                        r_fifo_clear <= 1'b0;
                        r_idx        <= 3'd0;
                        r_hold_vld   <= 1'b0;
                    end
                    FETCH: begin
                        if (!bus.fifo_empty)
                            r_state <= CAPTURE;
                    end
                    CAPTURE: begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd5) begin
                            r_hold_vld <= 1'b1;
                            r_state    <= HOLD;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                    HOLD: begin
                        if (bus.sample_req) begin
                            r_hold_vld <= 1'b0;
                            r_idx      <= 3'd0;
                            r_state    <= FETCH;
                        end
                    end
                    default: r_state <= CLEAR;
                endcase
            end
        end
    end

    // Holding data carries no reset; its validity flag guards every use.
    always_ff @(posedge i_clock) begin
        if (!i_reset && bus.run && (r_state == CAPTURE))
            r_hold[{w_slot, 3'b000} +: 8] <= bus.fifo_data;
    end

    assign bus.fifo_clear      = r_fifo_clear;
    assign bus.I_out           = r_i_out;
    assign bus.Q_out           = r_q_out;
    assign bus.iq_valid        = r_iq_valid;
    assign bus.underflow       = r_underflow;
    assign bus.underflow_count = r_ucount;

endmodule

// File: tb/tb_tx_iq_unpack.sv
// ---------------------------------------------------------------------------
// tb_tx_iq_unpack
// Bench for tx_iq_unpack. Two instances share all inputs: dut uses
// UNDERFLOW_ZERO=1, dut_h uses UNDERFLOW_ZERO=0. A queue-based non-show-ahead
// FIFO model feeds both. The randomized scenario predicts each response from
// byte order and sample availability time (13 cycles after run start or
// after the previous delivery).
// ---------------------------------------------------------------------------
module tb_tx_iq_unpack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_iq_unpack_if bus();
    tx_iq_unpack_if bus_h();

    tx_iq_unpack #(.UNDERFLOW_ZERO(1'b1)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    tx_iq_unpack #(.UNDERFLOW_ZERO(1'b0)) dut_h (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_h.slave)
    );

    assign bus_h.run        = bus.run;
    assign bus_h.fifo_data  = bus.fifo_data;
    assign bus_h.fifo_empty = bus.fifo_empty;
    assign bus_h.sample_req = bus.sample_req;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int unsigned  cyc   = 0;
    int unsigned  rd_seen = 0;
    byte unsigned fq[$];

    // One clock: sample FIFO strobes mid-cycle, then update the FIFO model
    // just after the edge so fifo_data appears one cycle after the read.
    task automatic tick();
        logic rd, clr;
        @(negedge clk);
        rd  = bus.fifo_rdreq;
        clr = bus.fifo_clear;
        n_vec++;
        if (rd && bus.fifo_empty) begin
            n_err++;
            $display("FAIL rdreq_while_empty: rdreq=%0b fifo_empty=%0b, required rdreq=0", rd, bus.fifo_empty);
        end
        n_vec++;
        if (bus_h.fifo_rdreq !== rd || bus_h.fifo_clear !== clr) begin
            n_err++;
            $display("FAIL param_indep: dut_h rd/clr=%0b/%0b, dut rd/clr=%0b/%0b", bus_h.fifo_rdreq, bus_h.fifo_clear, rd, clr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            fq.delete();
        end else if (rd && fq.size() > 0) begin
            bus.fifo_data = fq.pop_front();
            rd_seen++;
        end
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic push(input byte unsigned b);
        fq.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.sample_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise run and spend the CLEAR cycle (which flushes the FIFO).
    task automatic start_run();
        bus.run = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        start_run();
        for (int i = 0; i < 6; i++) push(8'(i + 1));
        repeat (5) tick();
        rst = 1'b1;
        bus.sample_req = 1'b1;
        tick();
        n_vec++;
        if (bus.fifo_clear !== 1'b1 || bus.fifo_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fifo_ctl: clear=%0b rdreq=%0b, required 1/0", bus.fifo_clear, bus.fifo_rdreq);
        end
        n_vec++;
        if (bus.iq_valid !== 1'b0 || bus.underflow !== 1'b0 || bus.underflow_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_status: valid=%0b uf=%0b cnt=%0h, required 0/0/0", bus.iq_valid, bus.underflow, bus.underflow_count);
        end
        n_vec++;
        if (bus.I_out !== 24'sd0 || bus.Q_out !== 24'sd0) begin
            n_err++;
            $display("FAIL reset_iq: I=%06h Q=%06h, required 000000/000000", bus.I_out, bus.Q_out);
        end
        bus.sample_req = 1'b0;
        rst = 1'b0;
        bus.run = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        start_run();
        push(8'h12); push(8'h34); push(8'h56); push(8'hAB); push(8'hCD); push(8'hEF);
        repeat (20) tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        n_vec++;
        if (bus.iq_valid !== 1'b1 || bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL basic_flags: valid=%0b uf=%0b, required 1/0", bus.iq_valid, bus.underflow);
        end
        n_vec++;
        if (bus.I_out !== 24'sh123456 || bus.Q_out !== 24'shABCDEF) begin
            n_err++;
            $display("FAIL basic_iq: I=%06h Q=%06h, required 123456/abcdef", bus.I_out, bus.Q_out);
        end
        tick();
        n_vec++;
        if (bus.iq_valid !== 1'b0 || bus.underflow_count !== 16'd0) begin
            n_err++;
            $display("FAIL basic_pulse: valid=%0b cnt=%0h, required 0/0", bus.iq_valid, bus.underflow_count);
        end
    endtask

    task automatic test_empty_underflow();
        int unsigned rd0;
        do_reset();
        rd0 = rd_seen;
        start_run();
        repeat (5) tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        n_vec++;
        if (bus.iq_valid !== 1'b1 || bus.underflow !== 1'b1 || bus.underflow_count !== 16'd1) begin
            n_err++;
            $display("FAIL empty_uf: valid=%0b uf=%0b cnt=%0h, required 1/1/1", bus.iq_valid, bus.underflow, bus.underflow_count);
        end
        n_vec++;
        if (bus.I_out !== 24'sd0 || bus.Q_out !== 24'sd0) begin
            n_err++;
            $display("FAIL empty_iq: I=%06h Q=%06h, required 000000/000000", bus.I_out, bus.Q_out);
        end
        n_vec++;
        if (rd_seen != rd0) begin
            n_err++;
            $display("FAIL empty_no_read: reads=%0d, required 0", rd_seen - rd0);
        end
    endtask

    task automatic test_hold_last();
        do_reset();
        start_run();
        push(8'h7F); push(8'hFF); push(8'hFF); push(8'h80); push(8'h00); push(8'h00);
        repeat (14) tick();
        bus.sample_req = 1'b1;
        tick();
        n_vec++;
        if (bus_h.I_out !== 24'sh7FFFFF || bus_h.Q_out !== 24'sh800000 || bus_h.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL hold_good: I=%06h Q=%06h uf=%0b, required 7fffff/800000/0", bus_h.I_out, bus_h.Q_out, bus_h.underflow);
        end
        tick();
        bus.sample_req = 1'b0;
        n_vec++;
        if (bus_h.underflow !== 1'b1 || bus_h.I_out !== 24'sh7FFFFF || bus_h.Q_out !== 24'sh800000) begin
            n_err++;
            $display("FAIL hold_repeat: uf=%0b I=%06h Q=%06h, required 1/7fffff/800000", bus_h.underflow, bus_h.I_out, bus_h.Q_out);
        end
        n_vec++;
        if (bus.underflow !== 1'b1 || bus.I_out !== 24'sd0 || bus.Q_out !== 24'sd0) begin
            n_err++;
            $display("FAIL zero_on_uf: uf=%0b I=%06h Q=%06h, required 1/000000/000000", bus.underflow, bus.I_out, bus.Q_out);
        end
    endtask

    task automatic test_run_drop();
        int unsigned rd0;
        int guard;
        do_reset();
        start_run();
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
        rd0 = rd_seen;
        guard = 0;
        while (rd_seen - rd0 < 3 && guard < 50) begin
            tick();
            guard++;
        end
        n_vec++;
        if (rd_seen - rd0 < 3) begin
            n_err++;
            $display("FAIL drop_reads_timeout: reads=%0d, required 3", rd_seen - rd0);
        end
        bus.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sample_req = (i == 2);
            tick();
            n_vec++;
            if (bus.fifo_clear !== 1'b1 || bus.iq_valid !== 1'b0 || bus.underflow !== 1'b0 || bus.underflow_count !== 16'd0) begin
                n_err++;
                $display("FAIL drop_idle[%0d]: clear=%0b valid=%0b uf=%0b cnt=%0h, required 1/0/0/0", i, bus.fifo_clear, bus.iq_valid, bus.underflow, bus.underflow_count);
            end
        end
        bus.sample_req = 1'b0;
        start_run();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
        repeat (15) tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        n_vec++;
        if (bus.iq_valid !== 1'b1 || bus.underflow !== 1'b0 || bus.I_out !== 24'sh112233 || bus.Q_out !== 24'sh445566) begin
            n_err++;
            $display("FAIL drop_refill: valid=%0b uf=%0b I=%06h Q=%06h, required 1/0/112233/445566", bus.iq_valid, bus.underflow, bus.I_out, bus.Q_out);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        start_run();
        for (int i = 0; i < 12; i++) push(8'(8'hA1 + i));
        repeat (11) tick();
        // Cycle 12 after run start is the CAPTURE of the sixth byte.
        bus.sample_req = 1'b1;
        tick();
        n_vec++;
        if (bus.iq_valid !== 1'b1 || bus.underflow !== 1'b1 || bus.underflow_count !== 16'd1) begin
            n_err++;
            $display("FAIL coincide_uf: valid=%0b uf=%0b cnt=%0h, required 1/1/1", bus.iq_valid, bus.underflow, bus.underflow_count);
        end
        tick();
        bus.sample_req = 1'b0;
        n_vec++;
        if (bus.underflow !== 1'b0 || bus.I_out !== 24'shA1A2A3 || bus.Q_out !== 24'shA4A5A6) begin
            n_err++;
            $display("FAIL coincide_next: uf=%0b I=%06h Q=%06h, required 0/a1a2a3/a4a5a6", bus.underflow, bus.I_out, bus.Q_out);
        end
    endtask

    task automatic test_random();
        byte unsigned mb[$];
        int unsigned avail, k, ucnt;
        logic [23:0] ei, eq, hi, hq;
        logic req, euf;
        byte unsigned b;
        do_reset();
        start_run();
        avail = cyc + 13;
        for (int i = 0; i < 240; i++) begin
            b = 8'($urandom);
            mb.push_back(b);
            push(b);
        end
        k = 0; ucnt = 0; ei = '0; eq = '0; hi = '0; hq = '0; euf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            req = ($urandom_range(0, 9) == 0);
            bus.sample_req = req;
            tick();
            bus.sample_req = 1'b0;
            if (req) begin
                if (cyc >= avail) begin
                    ei = {mb[6*k], mb[6*k+1], mb[6*k+2]};
                    eq = {mb[6*k+3], mb[6*k+4], mb[6*k+5]};
                    hi = ei; hq = eq;
                    k++;
                    avail = cyc + 13;
                    euf = 1'b0;
                end else begin
                    ei = '0; eq = '0;
                    if (ucnt < 65535) ucnt++;
                    euf = 1'b1;
                end
            end
            n_vec++;
            if (bus.iq_valid !== req || (req && bus.underflow !== euf) || (!req && bus.underflow !== 1'b0)) begin
                n_err++;
                $display("FAIL rand_flags@%0d: valid=%0b uf=%0b, required %0b/%0b", n, bus.iq_valid, bus.underflow, req, req & euf);
            end
            n_vec++;
            if (bus.I_out !== ei || bus.Q_out !== eq || bus_h.I_out !== hi || bus_h.Q_out !== hq) begin
                n_err++;
                $display("FAIL rand_iq@%0d: I=%06h Q=%06h hI=%06h hQ=%06h, required %06h/%06h/%06h/%06h", n, bus.I_out, bus.Q_out, bus_h.I_out, bus_h.Q_out, ei, eq, hi, hq);
            end
            n_vec++;
            if (bus.underflow_count !== 16'(ucnt)) begin
                n_err++;
                $display("FAIL rand_count@%0d: cnt=%0d, required %0d", n, bus.underflow_count, ucnt);
            end
        end
        n_vec++;
        if (k < 5) begin
            n_err++;
            $display("FAIL rand_deliveries: delivered=%0d, required at least 5", k);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        start_run();
        bus.sample_req = 1'b1;
        repeat (1000) tick();
        n_vec++;
        if (bus.underflow_count !== 16'd1000) begin
            n_err++;
            $display("FAIL sat_mid: cnt=%0d, required 1000", bus.underflow_count);
        end
        repeat (64535) tick();
        n_vec++;
        if (bus.underflow_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_reach: cnt=%0h, required ffff", bus.underflow_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (bus.underflow !== 1'b1 || bus.underflow_count !== 16'hFFFF || bus_h.underflow_count !== 16'hFFFF) begin
                n_err++;
                $display("FAIL sat_hold[%0d]: uf=%0b cnt=%0h hcnt=%0h, required 1/ffff/ffff", i, bus.underflow, bus.underflow_count, bus_h.underflow_count);
            end
        end
        bus.sample_req = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.run        = 1'b0;
        bus.sample_req = 1'b0;
        bus.fifo_data  = 8'h00;
        bus.fifo_empty = 1'b1;
        test_reset();
        test_basic();
        test_empty_underflow();
        test_hold_last();
        test_run_drop();
        test_coincide();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
